// File: rtl/interrupt_logic.sv
// interrupt_logic: sequences reset, NMI, IRQ and BRK entry.
// Pushes PCH/PCL/PSR to page 1 of the stack, then fetches the 16-bit vector
// and hands each vector byte to the register file as a one-cycle pulse.
module interrupt_logic (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        nmi,
    input  logic        irq,
    input  logic        brk,
    input  logic        boundary,
    input  logic [15:0] rf_pc,
    input  logic [7:0]  rf_psr,
    input  logic [7:0]  rf_s,
    input  logic        rf_i,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  intr_data,
    output logic        intr_set_pcl,
    output logic        intr_set_pch,
    output logic        intr_set_i,
    output logic        intr_set_b,
    output logic        intr_pushed,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH_PCH = 3'd1,
        PUSH_PCL = 3'd2,
        PUSH_PSR = 3'd3,
        VEC_LO   = 3'd4,
        VEC_HI   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        KIND_RESET = 2'd0,
        KIND_NMI   = 2'd1,
        KIND_IRQ   = 2'd2,
        KIND_BRK   = 2'd3
    } kind_t;

    state_t      state_q;
    state_t      state_d;
    kind_t       kind_q;
    kind_t       take_kind;

    logic [15:0] pc_q;
    logic [7:0]  psr_q;
    logic [7:0]  sp_q;

    logic        nmi_prev_q;
    logic        nmi_pend_q;
    logic        nmi_edge;

    logic [7:0]  data_q;
    logic        set_pcl_q;
    logic        set_pch_q;
    logic        set_i_q;
    logic        set_b_q;
    logic        pushed_q;

    logic        idle_free;
    logic        request;
    logic        accept;
    logic        in_push;
    logic        push_ack;
    logic        vec_lo_ack;
    logic        vec_hi_ack;
    logic [7:0]  vec_lo_byte;
    logic [7:0]  psr_push;

    // Request arbitration and transfer-completion qualifiers
    always_comb begin
        nmi_edge   = nmi & ~nmi_prev_q;
        idle_free  = (state_q == IDLE) && !set_pch_q;
        request    = nmi_pend_q | brk | (irq & ~rf_i);
        accept     = idle_free && boundary && request;
        if (nmi_pend_q) begin
            take_kind = KIND_NMI;
        end else if (brk) begin
            take_kind = KIND_BRK;
        end else begin
            take_kind = KIND_IRQ;
        end
        in_push    = (state_q == PUSH_PCH) || (state_q == PUSH_PCL) ||
                     (state_q == PUSH_PSR);
        push_ack   = in_push && mem_ack;
        vec_lo_ack = (state_q == VEC_LO) && mem_ack;
        vec_hi_ack = (state_q == VEC_HI) && mem_ack;
    end

    // State register; reset parks the machine at the reset-vector fetch
    always_ff @(posedge clk) begin
        if (rst_x) begin
            state_q <= VEC_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every non-idle state advances only on mem_ack
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PUSH_PCH;
                end
            end
            PUSH_PCH: begin
                if (mem_ack) begin
                    state_d = PUSH_PCL;
                end
            end
            PUSH_PCL: begin
                if (mem_ack) begin
                    state_d = PUSH_PSR;
                end
            end
            PUSH_PSR: begin
                if (mem_ack) begin
                    state_d = VEC_LO;
                end
            end
            VEC_LO: begin
                if (mem_ack) begin
                    state_d = VEC_HI;
                end
            end
            VEC_HI: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NMI edge history and pending flag; a fresh edge wins over the clear
    always_ff @(posedge clk) begin
        if (rst_x) begin
            nmi_prev_q <= 1'b0;
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_prev_q <= nmi;
            if (nmi_edge) begin
                nmi_pend_q <= 1'b1;
            end else if (accept && take_kind == KIND_NMI) begin
                nmi_pend_q <= 1'b0;
            end
        end
    end

    // Context capture at acceptance and stack pointer walk during pushes
    always_ff @(posedge clk) begin
        if (rst_x) begin
            kind_q <= KIND_RESET;
            pc_q   <= '0;
            psr_q  <= '0;
            sp_q   <= '0;
        end else if (accept) begin
            kind_q <= take_kind;
            pc_q   <= rf_pc;
            psr_q  <= rf_psr;
            sp_q   <= rf_s;
        end else if (push_ack) begin
            sp_q   <= sp_q - 8'd1;
        end
    end

    // One-cycle handshake pulses to the register file and vector data hold
    always_ff @(posedge clk) begin
        if (rst_x) begin
            data_q    <= '0;
            set_pcl_q <= 1'b0;
            set_pch_q <= 1'b0;
            set_i_q   <= 1'b0;
            set_b_q   <= 1'b0;
            pushed_q  <= 1'b0;
        end else begin
            set_pcl_q <= vec_lo_ack;
            set_i_q   <= vec_lo_ack;
            set_b_q   <= vec_lo_ack && (kind_q == KIND_BRK);
            set_pch_q <= vec_hi_ack;
            pushed_q  <= push_ack;
            if (vec_lo_ack || vec_hi_ack) begin
                data_q <= mem_rdata;
            end
        end
    end

    // Vector selection and the pushed status byte (bit5 forced, bit4 = BRK)
    always_comb begin
        unique case (kind_q)
            KIND_NMI:   vec_lo_byte = 8'hFA;
            KIND_RESET: vec_lo_byte = 8'hFC;
            default:    vec_lo_byte = 8'hFE;
        endcase
        psr_push    = psr_q;
        psr_push[5] = 1'b1;
        psr_push[4] = (kind_q == KIND_BRK);
    end

    // Output decode; rst_x masks everything combinationally so an abort is
    // immediate even though the state register only resets on the edge
    always_comb begin
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        busy         = 1'b1;
        intr_data    = '0;
        intr_set_pcl = 1'b0;
        intr_set_pch = 1'b0;
        intr_set_i   = 1'b0;
        intr_set_b   = 1'b0;
        intr_pushed  = 1'b0;
        if (!rst_x) begin
            busy         = (state_q != IDLE) || set_pch_q;
            intr_data    = data_q;
            intr_set_pcl = set_pcl_q;
            intr_set_pch = set_pch_q;
            intr_set_i   = set_i_q;
            intr_set_b   = set_b_q;
            intr_pushed  = pushed_q;
            unique case (state_q)
                PUSH_PCH: begin
                    mem_req   = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = {8'h01, sp_q};
                    mem_wdata = pc_q[15:8];
                end
                PUSH_PCL: begin
                    mem_req   = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = {8'h01, sp_q};
                    mem_wdata = pc_q[7:0];
                end
                PUSH_PSR: begin
                    mem_req   = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = {8'h01, sp_q};
                    mem_wdata = psr_push;
                end
                VEC_LO: begin
                    mem_req   = 1'b1;
                    mem_addr  = {8'hFF, vec_lo_byte};
                end
                VEC_HI: begin
                    mem_req   = 1'b1;
                    mem_addr  = {8'hFF, vec_lo_byte | 8'h01};
                end
                default: begin
                    mem_req   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_logic.sv
// tb_interrupt_logic: directed vectors for reset, IRQ, BRK, NMI and abort.
module tb_interrupt_logic;

    logic        clk = 1'b0;
    logic        rst_x;
    logic        nmi, irq, brk, boundary;
    logic [15:0] rf_pc;
    logic [7:0]  rf_psr, rf_s;
    logic        rf_i;
    logic        mem_req, mem_wr, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  intr_data;
    logic        intr_set_pcl, intr_set_pch, intr_set_i, intr_set_b;
    logic        intr_pushed, busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    interrupt_logic dut (
        .clk          (clk),
        .rst_x        (rst_x),
        .nmi          (nmi),
        .irq          (irq),
        .brk          (brk),
        .boundary     (boundary),
        .rf_pc        (rf_pc),
        .rf_psr       (rf_psr),
        .rf_s         (rf_s),
        .rf_i         (rf_i),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .intr_data    (intr_data),
        .intr_set_pcl (intr_set_pcl),
        .intr_set_pch (intr_set_pch),
        .intr_set_i   (intr_set_i),
        .intr_set_b   (intr_set_b),
        .intr_pushed  (intr_pushed),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got,
                            input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".req"},   {15'd0, mem_req},   16'd0);
        check_eq({tag, ".wr"},    {15'd0, mem_wr},    16'd0);
        check_eq({tag, ".addr"},  mem_addr,           16'h0000);
        check_eq({tag, ".wdata"}, {8'd0, mem_wdata},  16'h0000);
        check_eq({tag, ".data"},  {8'd0, intr_data},  16'h0000);
        check_eq({tag, ".pulses"},
                 {11'd0, intr_set_pcl, intr_set_pch, intr_set_i, intr_set_b, intr_pushed},
                 16'd0);
        check_eq({tag, ".busy"},  {15'd0, busy},      16'd1);
    endtask

    // One zero-wait push: check the write, ack it, check the pushed pulse
    task automatic push(input string tag, input logic [15:0] addr, input logic [7:0] data);
        check_eq({tag, ".req"},   {15'd0, mem_req},  16'd1);
        check_eq({tag, ".wr"},    {15'd0, mem_wr},   16'd1);
        check_eq({tag, ".addr"},  mem_addr,          addr);
        check_eq({tag, ".wdata"}, {8'd0, mem_wdata}, {8'd0, data});
        mem_ack = 1'b1;
        tick();
        check_eq({tag, ".pushed"}, {15'd0, intr_pushed}, 16'd1);
        check_eq({tag, ".busy"},   {15'd0, busy},        16'd1);
    endtask

    // Vector fetch from lo/lo+1, ending one cycle after the intr_set_pch pulse
    task automatic vec_read(input string tag, input logic [15:0] lo,
                            input logic [7:0] dlo, input logic [7:0] dhi,
                            input logic exp_b);
        check_eq({tag, ".lo_req"},  {15'd0, mem_req}, 16'd1);
        check_eq({tag, ".lo_wr"},   {15'd0, mem_wr},  16'd0);
        check_eq({tag, ".lo_addr"}, mem_addr,         lo);
        mem_ack   = 1'b1;
        mem_rdata = dlo;
        tick();
        check_eq({tag, ".lo_pulse"},
                 {12'd0, intr_set_pcl, intr_set_i, intr_set_b, intr_set_pch},
                 {12'd0, 1'b1, 1'b1, exp_b, 1'b0});
        check_eq({tag, ".lo_data"}, {8'd0, intr_data}, {8'd0, dlo});
        check_eq({tag, ".hi_addr"}, mem_addr,          lo | 16'h0001);
        check_eq({tag, ".hi_wr"},   {15'd0, mem_wr},   16'd0);
        mem_rdata = dhi;
        tick();
        check_eq({tag, ".hi_pulse"},
                 {12'd0, intr_set_pcl, intr_set_i, intr_set_b, intr_set_pch},
                 16'd1);
        check_eq({tag, ".hi_data"}, {8'd0, intr_data}, {8'd0, dhi});
        check_eq({tag, ".hi_busy"}, {15'd0, busy},     16'd1);
        check_eq({tag, ".hi_req"},  {15'd0, mem_req},  16'd0);
        mem_ack = 1'b0;
        tick();
        check_eq({tag, ".done_busy"}, {15'd0, busy},         16'd0);
        check_eq({tag, ".done_pch"},  {15'd0, intr_set_pch}, 16'd0);
        check_eq({tag, ".hold_data"}, {8'd0, intr_data},     {8'd0, dhi});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin
        rst_x = 1'b1; nmi = 1'b0; irq = 1'b0; brk = 1'b0; boundary = 1'b1;
        rf_pc = 16'h0000; rf_psr = 8'h00; rf_s = 8'h00; rf_i = 1'b1;
        mem_ack = 1'b0; mem_rdata = 8'h00;

        // Reset hold and release to reset-vector fetch
        tick(); tick(); tick();
        check_quiet("rst");
        rst_x = 1'b0;
        #1;
        check_eq("rst.pushed", {15'd0, intr_pushed}, 16'd0);
        vec_read("rstvec", 16'hFFFC, 8'hEF, 8'hBE, 1'b0);

        // IRQ: context latched at acceptance, later rf_* changes ignored
        rf_pc = 16'h1234; rf_s = 8'hFD; rf_psr = 8'hC1; rf_i = 1'b0; irq = 1'b1;
        tick();
        irq = 1'b0; rf_pc = 16'hFFFF; rf_s = 8'h11; rf_psr = 8'h00;
        push("irq.pch", 16'h01FD, 8'h12);
        push("irq.pcl", 16'h01FC, 8'h34);
        push("irq.psr", 16'h01FB, 8'hE1);
        vec_read("irqvec", 16'hFFFE, 8'h00, 8'h80, 1'b0);

        // BRK with stack pointer wrapping 00 -> FF inside page 1
        rf_pc = 16'hABCD; rf_s = 8'h00; rf_psr = 8'h00; brk = 1'b1;
        tick();
        brk = 1'b0;
        push("brk.pch", 16'h0100, 8'hAB);
        push("brk.pcl", 16'h01FF, 8'hCD);
        push("brk.psr", 16'h01FE, 8'h30);
        vec_read("brkvec", 16'hFFFE, 8'h55, 8'h66, 1'b1);

        // NMI edge with masked IRQ; a second edge arrives mid-sequence
        rf_i = 1'b1; irq = 1'b1; nmi = 1'b1;
        rf_pc = 16'h5678; rf_s = 8'hF0; rf_psr = 8'h04;
        tick();
        check_eq("nmi.pend_wait", {15'd0, mem_req}, 16'd0);
        tick();
        push("nmi.pch", 16'h01F0, 8'h56);
        nmi = 1'b0;
        push("nmi.pcl", 16'h01EF, 8'h78);
        nmi = 1'b1;
        push("nmi.psr", 16'h01EE, 8'h24);
        vec_read("nmivec", 16'hFFFA, 8'h01, 8'h02, 1'b0);
        rf_pc = 16'h0203; rf_s = 8'hEE; rf_psr = 8'h24;
        tick();
        push("nmi2.pch", 16'h01EE, 8'h02);
        push("nmi2.pcl", 16'h01ED, 8'h03);
        push("nmi2.psr", 16'h01EC, 8'h24);
        vec_read("nmi2vec", 16'hFFFA, 8'h03, 8'h04, 1'b0);
        tick();
        check_eq("nmi.irq_masked", {15'd0, mem_req}, 16'd0);
        irq = 1'b0; nmi = 1'b0;

        // Wait states hold the bus steady, then reset aborts mid-push
        rf_pc = 16'h9ABC; rf_s = 8'h80; rf_psr = 8'h00; rf_i = 1'b0; irq = 1'b1;
        tick();
        irq = 1'b0;
        push("ws.pch", 16'h0180, 8'h9A);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("ws.addr",  mem_addr,           16'h017F);
            check_eq("ws.wdata", {8'd0, mem_wdata},  16'h00BC);
            check_eq("ws.req_wr", {14'd0, mem_req, mem_wr}, 16'd3);
        end
        rst_x = 1'b1;
        #1;
        check_quiet("abort");
        tick();
        check_quiet("abort_edge");
        rst_x = 1'b0;
        #1;
        check_eq("restart.pushed", {15'd0, intr_pushed}, 16'd0);
        vec_read("restart", 16'hFFFC, 8'h11, 8'h22, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/interrupt_logic.md
INTERRUPT_LOGIC -- requirements
Module: interrupt_logic

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_x  in  1  synchronous reset, active-high; 1 = reset, sampled on clk edge.
REQ-003 SHALL have inputs nmi 1 (edge-triggered request), irq 1 (level request), brk 1 (one-cycle BRK pulse from decode), boundary 1 (instruction boundary; sequences start only here).
REQ-004 SHALL have inputs rf_pc 16 (return address), rf_psr 8 (status), rf_s 8 (stack pointer), rf_i 1 (I flag), all from register file.
REQ-005 SHALL have bus ports mem_req out 1, mem_wr out 1, mem_addr out 16, mem_wdata out 8, mem_ack in 1, mem_rdata in 8.
REQ-006 SHALL have outputs to register file intr_data 8, intr_set_pcl 1, intr_set_pch 1, intr_set_i 1, intr_set_b 1, intr_pushed 1, plus busy 1 to core.

Function
REQ-007 States SHALL be IDLE, PUSH_PCH, PUSH_PCL, PUSH_PSR, VEC_LO, VEC_HI; mem_req=1 exactly in non-IDLE states.
REQ-008 nmi rising edge (0 in previous cycle, 1 now) SHALL set nmi_pend; nmi_pend clears only when an NMI sequence is accepted.
REQ-009 In IDLE with boundary=1, priority SHALL be nmi_pend > brk > (irq & ~rf_i); winner accepted that edge, state -> PUSH_PCH.
REQ-010 On acceptance SHALL latch rf_pc, rf_psr, rf_s and kind (NMI/BRK/IRQ); later changes on rf_* SHALL be ignored.
REQ-011 Push addresses SHALL be {8'h01, sp}; sp = latched rf_s, decremented mod 256 after each push ack (0x00 -> 0xFF, stays in page 1).
REQ-012 PUSH_PCH writes pc[15:8], PUSH_PCL writes pc[7:0], PUSH_PSR writes psr with bit5=1 and bit4=1 for BRK, 0 otherwise; mem_wr=1 in push states, 0 in VEC states.
REQ-013 mem_addr, mem_wr, mem_wdata SHALL be stable while mem_req=1 and mem_ack=0; a transfer completes in any cycle with mem_ack=1 (zero wait allowed); state advances on that edge.
REQ-014 intr_pushed SHALL pulse one cycle, in the cycle after each push ack.
REQ-015 VEC_LO/VEC_HI addresses SHALL be NMI FFFA/FFFB, RESET FFFC/FFFD, IRQ and BRK FFFE/FFFF.
REQ-016 On VEC_LO ack SHALL register intr_data<=mem_rdata, pulse intr_set_pcl and intr_set_i next cycle; intr_set_b pulses with them only for BRK.
REQ-017 On VEC_HI ack SHALL register intr_data<=mem_rdata, pulse intr_set_pch next cycle; state -> IDLE on the ack edge.
REQ-018 busy SHALL be 1 from acceptance edge through the intr_set_pch cycle inclusive; new acceptance requires busy=0.
REQ-019 nmi edges during a sequence SHALL set nmi_pend, taken at next boundary after busy=0; irq/brk during a sequence SHALL be ignored.
REQ-020 All intr_* outputs SHALL be 0 except in their defined pulse cycles; intr_data holds last value.

Reset
REQ-021 While rst_x=1: mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, intr_*=0, intr_data=0, busy=1, nmi_pend=0, nmi edge history=0.
REQ-022 First cycle after rst_x falls SHALL be VEC_LO, kind RESET, addr FFFC; no pushes, no intr_pushed.
REQ-023 rst_x=1 mid-sequence SHALL abort immediately, no further pulses; restart per REQ-022.

Verification
REQ-024 Reset release, mem_ack=1, rdata EF then BE -> reads FFFC, FFFD; intr_set_pcl+intr_set_i with data EF, then intr_set_pch with BE; busy=0 next cycle.
REQ-025 irq=1, rf_i=0, rf_pc=1234, rf_s=FD, rf_psr=C1, boundary -> writes 01FD=12, 01FC=34, 01FB=E1; three intr_pushed; reads FFFE/FFFF; intr_set_b=0.
REQ-026 brk pulse, rf_psr=00, rf_s=00 -> writes 0100, 01FF, 01FE (PSR=30); intr_set_b pulses with intr_set_pcl.
REQ-027 nmi edge and irq together, rf_i=1 -> NMI taken, vectors FFFA/FFFB; irq never taken; second nmi edge mid-sequence -> second NMI after busy=0.
REQ-028 mem_ack held 0 for 3 cycles in PUSH_PCL -> addr/wdata stable; then rst_x=1 -> outputs per REQ-021, restart at FFFC.
